// File: rtl/wb_bus_watchdog.sv
// wb_bus_watchdog: Wishbone pass-through that rejects address-map violations and aborts hung slave cycles.
module wb_bus_watchdog #(
  parameter int          TIMEOUT  = 1000,
  parameter logic [15:0] VALID_LO = 16'h0000,
  parameter logic [15:0] VALID_HI = 16'h7fff,
  parameter logic [15:0] RO_LO    = 16'h4000,
  parameter logic [15:0] RO_HI    = 16'h4fff,
  parameter logic [15:0] ERR_DATA = 16'hdead
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wd_en_i,
  input  logic        wbm_cyc_i,
  input  logic        wbm_stb_i,
  input  logic        wbm_we_i,
  input  logic [15:0] wbm_adr_i,
  input  logic [15:0] wbm_dat_i,
  input  logic [1:0]  wbm_id_i,
  output logic [15:0] wbm_dat_o,
  output logic        wbm_ack_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [15:0] wbs_adr_o,
  output logic [15:0] wbs_dat_o,
  input  logic [15:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  output logic        bm_memv,
  output logic        bm_timeout,
  output logic [1:0]  bm_wbm_id,
  output logic [15:0] bm_addr,
  output logic        bm_we
);
  typedef enum logic [1:0] {IDLE, FWD, ACK} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n, dat_n, adr_n, wdat_n, bm_addr_n;
  logic        ack_n, stb_n, we_n, memv_n, to_n, bm_we_n;
  logic [1:0]  id, id_n, bm_id_n;
  logic [16:0] lo_diff;
  logic        req, viol, expired;
  assign req = wbm_cyc_i & wbm_stb_i;
  // borrow bit gives adr < VALID_LO without a constant compare when VALID_LO is zero
  assign lo_diff = {1'b0, wbm_adr_i} - {1'b0, VALID_LO};
  assign viol = lo_diff[16] | (wbm_adr_i > VALID_HI) |
                (wbm_we_i & (wbm_adr_i >= RO_LO) & (wbm_adr_i <= RO_HI));
  // >= so that re-enabling after an overrun aborts on the very next edge
  assign expired = wd_en_i & (cnt >= 16'(TIMEOUT - 1));
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    dat_n     = wbm_dat_o;
    ack_n     = 1'b0;
    stb_n     = 1'b0;
    memv_n    = 1'b0;
    to_n      = 1'b0;
    adr_n     = wbs_adr_o;
    wdat_n    = wbs_dat_o;
    we_n      = wbs_we_o;
    id_n      = id;
    bm_addr_n = bm_addr;
    bm_we_n   = bm_we;
    bm_id_n   = bm_wbm_id;
    if (state == IDLE && req) begin
      adr_n  = wbm_adr_i;
      wdat_n = wbm_dat_i;
      we_n   = wbm_we_i;
      id_n   = wbm_id_i;
      if (viol) begin
        state_n   = ACK;
        dat_n     = ERR_DATA;
        ack_n     = 1'b1;
        memv_n    = 1'b1;
        bm_addr_n = wbm_adr_i;
        bm_we_n   = wbm_we_i;
        bm_id_n   = wbm_id_i;
      end else begin
        state_n = FWD;
        stb_n   = 1'b1;
        cnt_n   = 16'd0;
      end
    end else if (state == FWD) begin
      stb_n = 1'b1;
      if (!wbm_cyc_i) begin
        stb_n   = 1'b0;
        state_n = IDLE;
      end else if (wbs_ack_i) begin
        stb_n   = 1'b0;
        dat_n   = wbs_dat_i;
        ack_n   = 1'b1;
        state_n = ACK;
      end else if (expired) begin
        stb_n     = 1'b0;
        dat_n     = ERR_DATA;
        ack_n     = 1'b1;
        to_n      = 1'b1;
        bm_addr_n = wbs_adr_o;
        bm_we_n   = wbs_we_o;
        bm_id_n   = id;
        state_n   = ACK;
      end else begin
        cnt_n = (cnt == 16'hffff) ? cnt : cnt + 16'd1;
      end
    end else if (state != IDLE) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      id         <= 2'd0;
      wbm_dat_o  <= 16'd0;
      wbm_ack_o  <= 1'b0;
      wbs_cyc_o  <= 1'b0;
      wbs_stb_o  <= 1'b0;
      wbs_we_o   <= 1'b0;
      wbs_adr_o  <= 16'd0;
      wbs_dat_o  <= 16'd0;
      bm_memv    <= 1'b0;
      bm_timeout <= 1'b0;
      bm_wbm_id  <= 2'd0;
      bm_addr    <= 16'd0;
      bm_we      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      id         <= id_n;
      wbm_dat_o  <= dat_n;
      wbm_ack_o  <= ack_n;
      wbs_cyc_o  <= stb_n;
      wbs_stb_o  <= stb_n;
      wbs_we_o   <= we_n;
      wbs_adr_o  <= adr_n;
      wbs_dat_o  <= wdat_n;
      bm_memv    <= memv_n;
      bm_timeout <= to_n;
      bm_wbm_id  <= bm_id_n;
      bm_addr    <= bm_addr_n;
      bm_we      <= bm_we_n;
    end
  end
endmodule

// File: tb/tb_wb_bus_watchdog.sv
// tb_wb_bus_watchdog: randomized transactions checked against a per-transaction outcome model.
module tb_wb_bus_watchdog;
  localparam int TO = 8;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i, wd_en_i, wbm_cyc_i, wbm_stb_i, wbm_we_i, wbs_ack_i;
  logic [15:0] wbm_adr_i, wbm_dat_i, wbs_dat_i;
  logic [1:0]  wbm_id_i;
  logic [15:0] wbm_dat_o, wbs_adr_o, wbs_dat_o, bm_addr;
  logic        wbm_ack_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, bm_memv, bm_timeout, bm_we;
  logic [1:0]  bm_wbm_id;
  logic [72:0] outs;
  int n_cmp = 0, n_bad = 0;

  wb_bus_watchdog #(.TIMEOUT(TO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wd_en_i(wd_en_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_id_i(wbm_id_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i),
    .bm_memv(bm_memv), .bm_timeout(bm_timeout), .bm_wbm_id(bm_wbm_id),
    .bm_addr(bm_addr), .bm_we(bm_we)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  assign outs = {wbm_dat_o, wbm_ack_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o,
                 bm_memv, bm_timeout, bm_wbm_id, bm_addr, bm_we};

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ack_at: strobe cycle in which the slave acks (0 = never); en_at: strobe cycle where wd_en rises
  task automatic txn(input logic [15:0] a, input logic w, input logic [15:0] d, input logic [1:0] i,
                     input int ack_at, input logic wd, input int en_at);
    logic [15:0] rd, ed, got_dat;
    logic viol, exp_to, stb_ok;
    int tos, es, ec, sc, ack_cyc, n_ack, memv_n, to_n;
    rd = 16'($urandom);
    viol = (a > 16'h7fff) || (w && a >= 16'h4000 && a <= 16'h4fff);
    tos = wd ? TO : (en_at > 0 ? (en_at > TO ? en_at : TO) : 1 << 30);
    exp_to = !viol && !(ack_at > 0 && ack_at <= tos);
    if (viol) begin es = 0; ec = 1; ed = 16'hdead; end
    else if (!exp_to) begin es = ack_at; ec = ack_at + 1; ed = rd; end
    else begin es = tos; ec = tos + 1; ed = 16'hdead; end
    @(negedge wb_clk_i);
    wd_en_i = wd; wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = w; wbm_adr_i = a; wbm_dat_i = d; wbm_id_i = i;
    sc = 0; ack_cyc = 0; n_ack = 0; memv_n = 0; to_n = 0; stb_ok = 1; got_dat = 0;
    for (int n = 1; n <= 2100 && (ack_cyc == 0 || n <= ack_cyc + 1); n++) begin
      @(negedge wb_clk_i);
      if (wbm_ack_o) begin
        n_ack++;
        if (ack_cyc == 0) begin ack_cyc = n; got_dat = wbm_dat_o; end
      end
      memv_n += int'(bm_memv);
      to_n += int'(bm_timeout);
      if (bm_memv || bm_timeout) begin
        check("ev_with_ack", wbm_ack_o, 1);
        check("bm_addr", bm_addr, a);
        check("bm_we", bm_we, w);
        check("bm_wbm_id", bm_wbm_id, i);
      end
      if (wbs_stb_o) begin
        sc++;
        if ({wbs_cyc_o, wbs_adr_o, wbs_dat_o, wbs_we_o} !== {1'b1, a, d, w}) stb_ok = 0;
        if (sc == en_at) wd_en_i = 1;
      end
      wbs_ack_i = wbs_stb_o && sc == ack_at;
      wbs_dat_i = wbs_ack_i ? rd : 16'($urandom);
      if (wbm_ack_o) begin wbm_cyc_i = 0; wbm_stb_i = 0; end
    end
    wbs_ack_i = 0; wd_en_i = 1; wbm_cyc_i = 0; wbm_stb_i = 0;
    check("ack_cycle", ack_cyc, ec);
    check("ack_count", n_ack, 1);
    check("rd_data", got_dat, ed);
    check("memv_pulses", memv_n, viol);
    check("timeout_pulses", to_n, exp_to);
    check("strobe_cycles", sc, es);
    check("slave_req", stb_ok, 1);
  endtask

  initial begin
    logic [15:0] edges [6];
    int bad;
    edges = '{16'h3fff, 16'h4000, 16'h4fff, 16'h5000, 16'h7fff, 16'h8000};
    wb_rst_i = 0; wd_en_i = 1; wbm_cyc_i = 0; wbm_stb_i = 0; wbm_we_i = 0;
    wbm_adr_i = 0; wbm_dat_i = 0; wbm_id_i = 0; wbs_dat_i = 0; wbs_ack_i = 0;
    #23;
    check("reset_outs", outs, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1;
    txn(16'h0010, 0, 16'h0000, 0, 3, 1, 0);
    txn(16'h4100, 1, 16'h5555, 2, 2, 1, 0);
    txn(16'h4100, 0, 16'h0000, 1, 2, 1, 0);
    txn(16'h8000, 0, 16'h0000, 3, 1, 1, 0);
    txn(16'h0020, 1, 16'habcd, 0, 1, 1, 0);
    txn(16'h1000, 0, 16'h0000, 1, 0, 1, 0);
    txn(16'h1000, 0, 16'h0000, 1, TO, 1, 0);
    txn(16'h0100, 1, 16'h1111, 2, 2000, 0, 0);
    txn(16'h0200, 0, 16'h0000, 3, 0, 0, 20);
    txn(16'h0200, 1, 16'h2222, 1, 0, 0, 3);
    foreach (edges[k]) begin
      txn(edges[k], 1, 16'h7777, 2'(k), 1, 1, 0);
      txn(edges[k], 0, 16'h0000, 2'(k), 1, 1, 0);
    end
    // master abandons mid-forward
    @(negedge wb_clk_i);
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 0; wbm_adr_i = 16'h0040;
    repeat (3) @(negedge wb_clk_i);
    check("abandon_pre", wbs_stb_o, 1);
    wbm_cyc_i = 0; wbm_stb_i = 0;
    @(negedge wb_clk_i);
    check("abandon_drop", {wbs_cyc_o, wbs_stb_o}, 0);
    bad = 0;
    repeat (4) begin
      bad += int'(wbm_ack_o | bm_memv | bm_timeout);
      @(negedge wb_clk_i);
    end
    check("abandon_quiet", bad, 0);
    // reset in the middle of a forwarded write
    wbm_cyc_i = 1; wbm_stb_i = 1; wbm_we_i = 1; wbm_adr_i = 16'h0030; wbm_dat_i = 16'hbeef;
    repeat (3) @(negedge wb_clk_i);
    check("mid_fwd_stb", wbs_stb_o, 1);
    #1 wb_rst_i = 0;
    #1 check("reset_mid_fwd", outs, 0);
    wbm_cyc_i = 0; wbm_stb_i = 0;
    @(negedge wb_clk_i);
    wb_rst_i = 1;
    for (int t = 0; t < 40; t++) begin
      int r, ack_at, en_at;
      logic [15:0] a;
      logic w, wd;
      r = $urandom_range(0, 3);
      a = r == 0 ? 16'($urandom_range(0, 16'h3fff)) :
          r == 1 ? 16'($urandom_range(16'h4000, 16'h4fff)) :
          r == 2 ? 16'($urandom_range(16'h8000, 16'hffff)) : 16'($urandom_range(16'h5000, 16'h7fff));
      w = 1'($urandom_range(0, 1));
      wd = $urandom_range(0, 3) != 0;
      ack_at = $urandom_range(0, 12);
      en_at = wd ? 0 : $urandom_range(0, 20);
      if (!wd && en_at == 0 && ack_at == 0) ack_at = 15;
      txn(a, w, 16'($urandom), 2'($urandom), ack_at, wd, en_at);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge wb_clk_i);
        wbs_ack_i = 1;
        @(negedge wb_clk_i);
        wbs_ack_i = 0;
        check("stray_ack", {wbm_ack_o, wbs_stb_o}, 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_bus_watchdog.md
Name: wb_bus_watchdog

Overview:
- Wishbone pass-through stage between the master arbiter and the slave address decoder.
- Forwards each single transaction to the slaves. Rejects accesses that violate the address map, and aborts transactions whose slave never acknowledges.
- Produces the bm_* event signals consumed directly by the bus monitor register block.
- The master always receives an ack, so a hung or illegal access never stalls the bus.

Parameters:
- TIMEOUT, 1000: slave-strobe cycles allowed before abort; legal range 2..65535.
- VALID_LO, 16'h0000: lowest legal address.
- VALID_HI, 16'h7fff: highest legal address.
- RO_LO, 16'h4000: read-only region start (inclusive).
- RO_HI, 16'h4fff: read-only region end (inclusive).
- ERR_DATA, 16'hdead: read data returned on violation or timeout.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- wd_en_i  in  1  1 = timeout checking enabled; 0 = wait forever on the slave.
- wbm_cyc_i  in  1  master cycle.
- wbm_stb_i  in  1  master strobe.
- wbm_we_i  in  1  master write enable.
- wbm_adr_i  in  16  master address.
- wbm_dat_i  in  16  master write data.
- wbm_id_i  in  2  arbiter grant id of the current master.
- wbm_dat_o  out  16  read data to master.
- wbm_ack_o  out  1  ack to master.
- wbs_cyc_o  out  1  slave cycle.
- wbs_stb_o  out  1  slave strobe.
- wbs_we_o  out  1  slave write enable.
- wbs_adr_o  out  16  slave address.
- wbs_dat_o  out  16  slave write data.
- wbs_dat_i  in  16  slave read data.
- wbs_ack_i  in  1  slave ack.
- bm_memv  out  1  one-cycle memory-violation pulse.
- bm_timeout  out  1  one-cycle timeout pulse.
- bm_wbm_id  out  2  id of the offending master.
- bm_addr  out  16  offending address.
- bm_we  out  1  offending write enable.

Behaviour:
- Reset (wb_rst_i low, async):
  - state = IDLE.
  - All outputs 0, including wbm_dat_o = 0, wbs_* = 0 and bm_* = 0.
  - Timeout counter = 0.
- All outputs are registered.
- wbs_adr_o, wbs_dat_o, wbs_we_o and the bm_addr/bm_we/bm_wbm_id fields come from request latches. These load when IDLE accepts a request.
- Violation rule, checked on the latched request: violation = (adr < VALID_LO) | (adr > VALID_HI) | (we & RO_LO <= adr <= RO_HI). Reads of the RO region are legal.
- IDLE:
  - On wbm_cyc_i & wbm_stb_i, latch adr/dat/we/id.
  - If violation: go to ACK with wbm_dat_o = ERR_DATA and bm_memv = 1. The slave is never strobed.
  - Otherwise: go to FWD with wbs_cyc_o = wbs_stb_o = 1 and counter = 0.
- FWD:
  - If wbm_cyc_i = 0 (master abandons): drop wbs_cyc_o/stb_o, go to IDLE. No ack, no event.
  - Else if wbs_ack_i: drop the slave strobes, wbm_dat_o = wbs_dat_i, wbm_ack_o = 1, go to ACK.
  - Else if wd_en_i & counter == TIMEOUT-1: drop the slave strobes, wbm_dat_o = ERR_DATA, wbm_ack_o = 1, bm_timeout = 1, go to ACK.
  - Else counter + 1. The counter is 16 bits and saturates at 16'hffff when wd_en_i = 0, so it never wraps.
- ACK:
  - wbm_ack_o is high for exactly this one cycle.
  - bm_memv/bm_timeout, if set, are high for exactly this cycle; bm_addr/bm_we/bm_wbm_id are valid with them.
  - Next state is IDLE. IDLE cannot accept during ACK, so there is no double accept.
- bm_addr/bm_we/bm_wbm_id hold their last event values between events. The monitor samples them only on a pulse.
- Latency:
  - Violation: request sampled at edge 0, ack in cycle 1.
  - Forwarded: slave strobe from cycle 1; slave ack in cycle k gives master ack in cycle k+1.
  - Timeout: slave strobe high for exactly TIMEOUT cycles, master ack the cycle after.
- Simultaneous wbs_ack_i and timeout in the same cycle: the ack wins, with slave data and no bm_timeout.
- bm_memv and bm_timeout are never high together.
- wd_en_i deasserted mid-FWD freezes the check. Reasserting it continues from the current count, and if the count is already >= TIMEOUT-1 the abort happens on the next cycle.
- Reset asserted mid-transaction clears everything immediately. No ack and no event are produced.
- A stray wbs_ack_i while not in FWD is ignored.

Test Plan:
- Read 16'h0010, slave acks 3 cycles after strobe with 16'h1234 -> wbm_ack_o one cycle later with wbm_dat_o = 16'h1234; bm_memv = bm_timeout = 0.
- Write 16'h4100 (RO region), id 2 -> no slave strobe; ack in cycle 1 with 16'hdead; bm_memv one cycle with bm_addr = 16'h4100, bm_we = 1, bm_wbm_id = 2. Read of 16'h4100 is forwarded normally.
- Read 16'h8000 -> bm_memv pulse, ERR_DATA returned. A subsequent legal access forwards normally.
- TIMEOUT = 8, slave never acks -> wbs_stb_o high exactly 8 cycles, then ack with 16'hdead and bm_timeout one cycle; bm_addr = request address.
- TIMEOUT = 8, slave acks in the 8th strobe cycle -> normal data, no bm_timeout. With wd_en_i = 0 and an ack after 2000 cycles -> normal completion.
- Master drops wbm_cyc_i during FWD -> slave strobes drop next cycle, no ack, no event. Reset asserted mid-FWD -> all outputs 0 asynchronously.
